// File: rtl/priority_encoder_arbiter.sv
// priority_encoder_arbiter
// Turns an N-bit request vector into a registered binary index and a one-hot
// grant. Mode_In selects fixed priority (highest index wins) or round-robin.
// A grant is held until Valid_Out/Ready_In complete a handshake. On that same
// edge the next winner can be loaded, so grants can follow with no gap.
// Optional feature macro: PRIORITY_ENCODER_ARBITER_GRANT_COUNT_EN adds a 16-bit
// saturating count of completed handshakes on Grant_Count_Out.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no live grant, outputs all zero, waiting for Enable & request
// HOLD  | grant registered and frozen until Ready_In completes handshake
module priority_encoder_arbiter #(
  parameter int NUM_INPUTS = 8
) (
  input  logic                              Clock_In,
  input  logic                              Reset_In,
  input  logic                              Enable_In,
  input  logic                              Mode_In,
  input  logic [NUM_INPUTS-1:0]             Request_In,
  input  logic                              Ready_In,
  output logic                              Valid_Out,
  output logic [$clog2(NUM_INPUTS)-1:0]     Encoded_Value_Out,
  output logic [NUM_INPUTS-1:0]             Grant_Out
`ifdef PRIORITY_ENCODER_ARBITER_GRANT_COUNT_EN
  ,
  output logic [15:0]                       Grant_Count_Out
`endif
);

  localparam int ENCODED_WIDTH = $clog2(NUM_INPUTS);
  localparam logic [ENCODED_WIDTH-1:0] LAST_IDX = ENCODED_WIDTH'(NUM_INPUTS - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t                     r_state;
  logic                       r_valid;
  logic [ENCODED_WIDTH-1:0]   r_encoded;
  logic [NUM_INPUTS-1:0]      r_grant;
  logic [ENCODED_WIDTH-1:0]   r_ptr;

  logic                       w_any_req;
  logic                       w_handshake;
  logic [ENCODED_WIDTH-1:0]   w_ptr_dec;
  logic [ENCODED_WIDTH-1:0]   w_ptr_eff;
  logic [NUM_INPUTS-1:0]      w_low_mask;
  logic [NUM_INPUTS-1:0]      w_low_req;
  logic [ENCODED_WIDTH-1:0]   w_fixed_win;
  logic [ENCODED_WIDTH-1:0]   w_low_win;
  logic [ENCODED_WIDTH-1:0]   w_winner;
  logic [NUM_INPUTS-1:0]      w_winner_onehot;

`ifdef PRIORITY_ENCODER_ARBITER_GRANT_COUNT_EN
  logic [15:0]                r_grant_count;
`endif

  // Highest set bit of a vector; zero when nothing is set.
  function automatic logic [ENCODED_WIDTH-1:0] f_highest(input logic [NUM_INPUTS-1:0] v);
    logic [ENCODED_WIDTH-1:0] pick;
    pick = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      if (v[k]) pick = ENCODED_WIDTH'(k);
    end
    return pick;
  endfunction

  assign w_any_req   = |Request_In;
  assign w_handshake = (r_state == S_HOLD) && Ready_In;

  // The pointer wraps from 0 to the last real requester, not to 2^W-1.
  assign w_ptr_dec = (r_encoded == '0) ? LAST_IDX : (r_encoded - ENCODED_WIDTH'(1));

  // A round-robin handshake moves the pointer on the same edge that loads the
  // next winner, so that winner has to be searched from the updated pointer.
  assign w_ptr_eff = (w_handshake && Mode_In) ? w_ptr_dec : r_ptr;

  // Round-robin search order is P, P-1, .., 0, N-1, .., P+1. That is the
  // highest request at or below P if one exists, else the highest overall.
  always_comb begin
    w_low_mask = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      w_low_mask[k] = (k <= int'(w_ptr_eff));
    end
  end

  assign w_low_req       = Request_In & w_low_mask;
  assign w_fixed_win     = f_highest(Request_In);
  assign w_low_win       = f_highest(w_low_req);
  assign w_winner        = (Mode_In && (|w_low_req)) ? w_low_win : w_fixed_win;
  assign w_winner_onehot = NUM_INPUTS'(1) << w_winner;

  // Arbitration FSM with registered outputs and the round-robin pointer.
  always_ff @(posedge Clock_In) begin
    if (Reset_In) begin
      r_state   <= S_IDLE;
      r_valid   <= 1'b0;
      r_encoded <= '0;
      r_grant   <= '0;
      r_ptr     <= LAST_IDX;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Enable_In && w_any_req) begin
            r_valid   <= 1'b1;
            r_encoded <= w_winner;
            r_grant   <= w_winner_onehot;
            r_state   <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (Ready_In) begin
            if (Mode_In) r_ptr <= w_ptr_dec;
            if (Enable_In && w_any_req) begin
              r_encoded <= w_winner;
              r_grant   <= w_winner_onehot;
            end else begin
              r_valid   <= 1'b0;
              r_encoded <= '0;
              r_grant   <= '0;
              r_state   <= S_IDLE;
            end
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_valid   <= 1'b0;
          r_encoded <= '0;
          r_grant   <= '0;
        end
      endcase
    end
  end

`ifdef PRIORITY_ENCODER_ARBITER_GRANT_COUNT_EN
  // Saturating count of completed handshakes.
  always_ff @(posedge Clock_In) begin
    if (Reset_In) begin
      r_grant_count <= '0;
    end else if (w_handshake && (r_grant_count != 16'hFFFF)) begin
      r_grant_count <= r_grant_count + 16'd1;
    end
  end

  assign Grant_Count_Out = r_grant_count;
`endif

  assign Valid_Out         = r_valid;
  assign Encoded_Value_Out = r_encoded;
  assign Grant_Out         = r_grant;

endmodule

// File: tb/tb_priority_encoder_arbiter.sv
// Directed bench for priority_encoder_arbiter: an 8-input instance and a
// 5-input instance share clock and control lines but have separate requests.
module tb_priority_encoder_arbiter;

  logic       clk;
  logic       rst;
  logic       en;
  logic       mode;
  logic       rdy;
  logic [7:0] req8;
  logic [4:0] req5;

  logic       val8;
  logic [2:0] enc8;
  logic [7:0] gnt8;
  logic       val5;
  logic [2:0] enc5;
  logic [4:0] gnt5;
`ifdef PRIORITY_ENCODER_ARBITER_GRANT_COUNT_EN
  logic [15:0] cnt8;
  logic [15:0] cnt5;
`endif

  int n_cmp = 0;
  int n_err = 0;

  priority_encoder_arbiter #(.NUM_INPUTS(8)) u_dut8 (
    .Clock_In          (clk),
    .Reset_In          (rst),
    .Enable_In         (en),
    .Mode_In           (mode),
    .Request_In        (req8),
    .Ready_In          (rdy),
    .Valid_Out         (val8),
    .Encoded_Value_Out (enc8),
    .Grant_Out         (gnt8)
`ifdef PRIORITY_ENCODER_ARBITER_GRANT_COUNT_EN
    ,
    .Grant_Count_Out   (cnt8)
`endif
  );

  priority_encoder_arbiter #(.NUM_INPUTS(5)) u_dut5 (
    .Clock_In          (clk),
    .Reset_In          (rst),
    .Enable_In         (en),
    .Mode_In           (mode),
    .Request_In        (req5),
    .Ready_In          (rdy),
    .Valid_Out         (val5),
    .Encoded_Value_Out (enc5),
    .Grant_Out         (gnt5)
`ifdef PRIORITY_ENCODER_ARBITER_GRANT_COUNT_EN
    ,
    .Grant_Count_Out   (cnt5)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk8(input string tag, input logic v, input logic [2:0] e, input logic [7:0] g);
    chk({tag, ".valid"}, 32'(val8), 32'(v));
    chk({tag, ".enc"},   32'(enc8), 32'(e));
    chk({tag, ".grant"}, 32'(gnt8), 32'(g));
  endtask

  task automatic chk5(input string tag, input logic v, input logic [2:0] e, input logic [4:0] g);
    chk({tag, ".valid"}, 32'(val5), 32'(v));
    chk({tag, ".enc"},   32'(enc5), 32'(e));
    chk({tag, ".grant"}, 32'(gnt5), 32'(g));
  endtask

  logic [2:0] rr_ff [9] = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7};
  logic [2:0] rr_n5 [7] = '{3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd4, 3'd3};

  initial begin
    rst = 1'b1; en = 1'b0; mode = 1'b0; rdy = 1'b0; req8 = '0; req5 = '0;
    tick();
    tick();
    chk8("reset8", 1'b0, 3'd0, 8'h00);
    chk5("reset5", 1'b0, 3'd0, 5'h00);

    // Fixed priority capture with backpressure.
    rst = 1'b0; en = 1'b1; rdy = 1'b0; req8 = 8'b0010_1100;
    tick();
    chk8("fixed_first", 1'b1, 3'd5, 8'h20);
    req8 = 8'b1000_0000;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk8("backpressure", 1'b1, 3'd5, 8'h20);
    end
    rdy = 1'b1;
    tick();
    chk8("no_bubble", 1'b1, 3'd7, 8'h80);
    en = 1'b0;
    tick();
    chk8("release", 1'b0, 3'd0, 8'h00);
    tick();
    chk8("ready_in_idle", 1'b0, 3'd0, 8'h00);

    // Round robin between two requesters.
    mode = 1'b1; en = 1'b1; rdy = 1'b1; req8 = 8'b1000_0001;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk8("rr_pair", 1'b1, (i % 2 == 0) ? 3'd7 : 3'd0, (i % 2 == 0) ? 8'h80 : 8'h01);
    end

    // Round robin over all eight, then a reset mid-sequence.
    req8 = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk8("rr_all", 1'b1, rr_ff[i], 8'(1) << rr_ff[i]);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      chk8("rr_again", 1'b1, 3'(6 - i), 8'(1) << (6 - i));
    end
    rst = 1'b1;
    tick();
    chk8("rr_reset", 1'b0, 3'd0, 8'h00);
    rst = 1'b0;
    tick();
    chk8("rr_after_reset", 1'b1, 3'd7, 8'h80);

    // No grant when disabled or when nothing requests.
    en = 1'b0;
    tick();
    chk8("drain", 1'b0, 3'd0, 8'h00);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk8("disabled", 1'b0, 3'd0, 8'h00);
    end
    en = 1'b1; req8 = 8'h00;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk8("no_request", 1'b0, 3'd0, 8'h00);
    end

    // Grant survives Enable and request dropping while held.
    mode = 1'b0; rdy = 1'b0; req8 = 8'h04;
    tick();
    chk8("hold_load", 1'b1, 3'd2, 8'h04);
    en = 1'b0; req8 = 8'h10; mode = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk8("hold_frozen", 1'b1, 3'd2, 8'h04);
    end
    rdy = 1'b1;
    tick();
    chk8("hold_release", 1'b0, 3'd0, 8'h00);

    // Five-input round robin: wraps to 4, never past it.
    req8 = 8'h00; rst = 1'b1;
    tick();
    rst = 1'b0; mode = 1'b1; en = 1'b1; rdy = 1'b1; req5 = 5'b11111;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk5("rr_n5", 1'b1, rr_n5[i], 5'(1) << rr_n5[i]);
    end
`ifdef PRIORITY_ENCODER_ARBITER_GRANT_COUNT_EN
    chk("grant_count_n5", 32'(cnt5), 32'd6);
    chk("grant_count_n8", 32'(cnt8), 32'd0);
`endif
    req5 = '0; en = 1'b0;
    tick();
    chk5("n5_release", 1'b0, 3'd0, 5'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/priority_encoder_arbiter.md
Name: priority_encoder_arbiter

Overview:
- Parametrised successor to the fixed 8:3 high-priority encoder.
- Encodes an N-bit request vector into a binary index plus a one-hot grant, in either fixed high-priority mode or round-robin mode.
- Output is registered and held under a valid/ready handshake, so the block can drive a downstream shared resource directly.
- Sits between request sources and a shared consumer such as a bus, port or FIFO write side.

Parameters:
- NUM_INPUTS, 8, number of request lines; legal range 2..256, and non-power-of-two values are legal.
- ENCODED_WIDTH, $clog2(NUM_INPUTS), width of the encoded index; derived, never overridden.

Ports:
- Clock_In  input  1  single clock; all logic on rising edge
- Reset_In  input  1  synchronous, active-high reset
- Enable_In  input  1  capture gate; a new arbitration is taken only when high
- Mode_In  input  1  0 = fixed priority (highest index wins), 1 = round-robin
- Request_In  input  NUM_INPUTS  request vector, bit k = requester k
- Ready_In  input  1  downstream accepts current grant
- Valid_Out  output  1  Encoded_Value_Out/Grant_Out hold a live grant
- Encoded_Value_Out  output  ENCODED_WIDTH  index of granted requester
- Grant_Out  output  NUM_INPUTS  one-hot grant; all-zero when Valid_Out=0

Behaviour:
- Reset (sync, Reset_In=1 at rising edge):
  - Valid_Out=0, Encoded_Value_Out=0, Grant_Out=0.
  - RR pointer P=NUM_INPUTS-1; state IDLE.
  - Reset overrides all other inputs, including mid-HOLD; the held grant is discarded.
- Winner selection (combinational, from live Request_In):
  - Fixed mode: highest set index.
  - RR mode: search indices P, P-1, ..., 0, NUM_INPUTS-1, ..., P+1; the first set bit wins.
  - At reset P=N-1, so RR equals fixed priority until the first RR handshake.
- FSM, 2 states:
  - IDLE: if Enable_In=1 and |Request_In=1, register the winner into Encoded_Value_Out/Grant_Out, set Valid_Out=1, go to HOLD. Otherwise remain in IDLE with outputs 0.
  - Latency: request to Valid_Out is exactly 1 clock.
  - HOLD: outputs frozen while Ready_In=0. Request_In, Enable_In and Mode_In changes are ignored. A grant is never retracted, even if its request drops.
  - Handshake in HOLD (Valid_Out=1 and Ready_In=1 on a rising edge):
    - If Mode_In=1, P is set to (granted index - 1) mod NUM_INPUTS, so 0 wraps to N-1. If Mode_In=0, P is unchanged.
    - On the same edge, if Enable_In=1 and |Request_In=1, load the next winner, computed with the updated P, and stay in HOLD. This gives back-to-back grants with no bubble.
    - Otherwise clear the outputs to 0, set Valid_Out=0, go to IDLE.
- Ready_In while in IDLE has no effect.
- Request_In all-zero: no grant. Outputs are 0, never Z or X.
- Arithmetic: pointer decrement wraps at 0 to NUM_INPUTS-1, not to 2^ENCODED_WIDTH-1.
- Invariant: when Valid_Out=1, Encoded_Value_Out < NUM_INPUTS and Grant_Out = 1 << Encoded_Value_Out.

Optional Feature:
- Macro: PRIORITY_ENCODER_ARBITER_GRANT_COUNT_EN.
- Defined:
  - Adds output port Grant_Count_Out, 16 bits: count of completed handshakes.
  - Reset to 0 by Reset_In; increments by 1 per handshake; saturates at 16'hFFFF with no wrap.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- N=8, fixed mode, Enable=1, Ready=1, Request=8'b0010_1100 after reset -> next clock Valid=1, Encoded=5, Grant=8'b0010_0000.
- Backpressure: hold Ready=0 for 4 clocks while Request changes to 8'b1000_0000 -> outputs stay 5/8'b0010_0000. Raise Ready=1 -> next clock Encoded=7, with no bubble cycle.
- RR mode, Request=8'b1000_0001 constant, Ready=1 -> Encoded sequence 7,0,7,0, with Valid continuously 1.
- RR mode, Request=8'hFF, Ready=1 -> 7,6,5,4,3,2,1,0,7. Assert Reset_In mid-sequence -> next clock Valid=0, Grant=0. Reapply -> first grant 7.
- Enable=0 with Request=8'hFF, or Enable=1 with Request=0 -> Valid stays 0, Encoded=0, Grant=0 for 10 clocks. Drop Enable while in HOLD -> grant held until handshake.
- NUM_INPUTS=5, RR mode, Request=5'b11111 -> 4,3,2,1,0,4, with ENCODED_WIDTH=3 and Encoded never 5..7. With the macro defined, Grant_Count_Out=6 after six handshakes.
